// File: rtl/ycbcr_skin_bbox_pkg.sv
// Shared definitions for the YCbCr skin classifier: pixel width, default frame size
// and the default skin window that the threshold shadows come out of reset with.
package ycbcr_skin_bbox_pkg;

    localparam int PIX_W      = 8;
    localparam int DEF_WIDTH  = 64;
    localparam int DEF_HEIGHT = 64;

    typedef struct packed {
        logic [PIX_W-1:0] yMin;
        logic [PIX_W-1:0] cbMin;
        logic [PIX_W-1:0] cbMax;
        logic [PIX_W-1:0] crMin;
        logic [PIX_W-1:0] crMax;
    } skinWindow_t;

    localparam skinWindow_t DEF_WINDOW = '{
        yMin:  8'd40,
        cbMin: 8'd77,
        cbMax: 8'd127,
        crMin: 8'd133,
        crMax: 8'd173
    };

endpackage

// File: rtl/ycbcr_in_range.sv
// Inclusive window compare lo <= value <= hi on unsigned pixel components.
// A window with lo > hi can never be satisfied, which is how a window is disabled.
module ycbcr_in_range
    import ycbcr_skin_bbox_pkg::*;
(
    input  logic [PIX_W-1:0] value,
    input  logic [PIX_W-1:0] lo,
    input  logic [PIX_W-1:0] hi,
    output logic             inRange
);

    assign inRange = (value >= lo) && (value <= hi);

endmodule

// File: rtl/ycbcr_skin_bbox.sv
// Skin classifier on a raster YCbCr stream: per-pixel mask output plus per-frame skin
// pixel count and bounding box, published with a one-cycle frame-done pulse.
module ycbcr_skin_bbox
    import ycbcr_skin_bbox_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int XW     = 6,
    parameter int YW     = 6,
    parameter int CW     = 13
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic [PIX_W-1:0] iY,
    input  logic [PIX_W-1:0] iCb,
    input  logic [PIX_W-1:0] iCr,
    input  logic [PIX_W-1:0] iYMin,
    input  logic [PIX_W-1:0] iCbMin,
    input  logic [PIX_W-1:0] iCbMax,
    input  logic [PIX_W-1:0] iCrMin,
    input  logic [PIX_W-1:0] iCrMax,
    output logic             oValid,
    output logic             oMask,
    output logic             oFrameDone,
    output logic [CW-1:0]    oCount,
    output logic             oBoxValid,
    output logic [XW-1:0]    oXMin,
    output logic [XW-1:0]    oXMax,
    output logic [YW-1:0]    oYMin,
    output logic [YW-1:0]    oYMax
);

    skinWindow_t     portWin;
    skinWindow_t     shadowWin;
    skinWindow_t     activeWin;
    logic [XW-1:0]   xPos;
    logic [YW-1:0]   yPos;
    logic            atOrigin;
    logic            lastX;
    logic            lastPix;
    logic            yOk;
    logic            cbOk;
    logic            crOk;

    logic            s1Valid;
    logic            s1YOk;
    logic            s1CbOk;
    logic            s1CrOk;
    logic [XW-1:0]   s1X;
    logic [YW-1:0]   s1Y;
    logic            s1Last;
    logic            s1Match;

    logic [CW-1:0]   accCnt;
    logic [XW-1:0]   accXMin;
    logic [XW-1:0]   accXMax;
    logic [YW-1:0]   accYMin;
    logic [YW-1:0]   accYMax;
    logic            accAny;
    logic [CW-1:0]   nCnt;
    logic [XW-1:0]   nXMin;
    logic [XW-1:0]   nXMax;
    logic [YW-1:0]   nYMin;
    logic [YW-1:0]   nYMax;
    logic            nAny;

    assign portWin = '{yMin: iYMin, cbMin: iCbMin, cbMax: iCbMax, crMin: iCrMin, crMax: iCrMax};

    assign atOrigin = (xPos == '0) && (yPos == '0);
    assign lastX    = (xPos == XW'(WIDTH - 1));
    assign lastPix  = lastX && (yPos == YW'(HEIGHT - 1));

    // Pixel (0,0) is classified with the live port thresholds it latches; the rest of the frame uses the shadow.
    assign activeWin = atOrigin ? portWin : shadowWin;

    assign yOk = (iY >= activeWin.yMin);

    ycbcr_in_range u_cbRange (
        .value   (iCb),
        .lo      (activeWin.cbMin),
        .hi      (activeWin.cbMax),
        .inRange (cbOk)
    );

    ycbcr_in_range u_crRange (
        .value   (iCr),
        .lo      (activeWin.crMin),
        .hi      (activeWin.crMax),
        .inRange (crOk)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            xPos      <= '0;
            yPos      <= '0;
            shadowWin <= DEF_WINDOW;
        end else if (iValid) begin
            if (atOrigin) begin
                shadowWin <= portWin;
            end
            if (lastX) begin
                xPos <= '0;
                yPos <= lastPix ? '0 : yPos + YW'(1);
            end else begin
                xPos <= xPos + XW'(1);
            end
        end
    end

    // Stage 1 data holds across gaps; only the valid bit drops.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1Valid <= 1'b0;
            s1YOk   <= 1'b0;
            s1CbOk  <= 1'b0;
            s1CrOk  <= 1'b0;
            s1X     <= '0;
            s1Y     <= '0;
            s1Last  <= 1'b0;
        end else begin
            s1Valid <= iValid;
            if (iValid) begin
                s1YOk  <= yOk;
                s1CbOk <= cbOk;
                s1CrOk <= crOk;
                s1X    <= xPos;
                s1Y    <= yPos;
                s1Last <= lastPix;
            end
        end
    end

    assign s1Match = s1YOk && s1CbOk && s1CrOk;

    always_comb begin
        nCnt  = accCnt;
        nXMin = accXMin;
        nXMax = accXMax;
        nYMin = accYMin;
        nYMax = accYMax;
        nAny  = accAny;
        if (s1Match) begin
            nCnt = accCnt + CW'(1);
            nAny = 1'b1;
            if (!accAny) begin
                nXMin = s1X;
                nXMax = s1X;
                nYMin = s1Y;
                nYMax = s1Y;
            end else begin
                nXMin = (s1X < accXMin) ? s1X : accXMin;
                nXMax = (s1X > accXMax) ? s1X : accXMax;
                nYMin = (s1Y < accYMin) ? s1Y : accYMin;
                nYMax = (s1Y > accYMax) ? s1Y : accYMax;
            end
        end
    end

    // Working set clears on the last pixel so the next frame's first pixel starts from zero.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            accCnt  <= '0;
            accXMin <= '0;
            accXMax <= '0;
            accYMin <= '0;
            accYMax <= '0;
            accAny  <= 1'b0;
        end else if (s1Valid) begin
            if (s1Last) begin
                accCnt  <= '0;
                accXMin <= '0;
                accXMax <= '0;
                accYMin <= '0;
                accYMax <= '0;
                accAny  <= 1'b0;
            end else begin
                accCnt  <= nCnt;
                accXMin <= nXMin;
                accXMax <= nXMax;
                accYMin <= nYMin;
                accYMax <= nYMax;
                accAny  <= nAny;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oValid     <= 1'b0;
            oMask      <= 1'b0;
            oFrameDone <= 1'b0;
            oCount     <= '0;
            oBoxValid  <= 1'b0;
            oXMin      <= '0;
            oXMax      <= '0;
            oYMin      <= '0;
            oYMax      <= '0;
        end else begin
            oValid     <= s1Valid;
            oFrameDone <= s1Valid && s1Last;
            if (s1Valid) begin
                oMask <= s1Match;
                if (s1Last) begin
                    oCount    <= nCnt;
                    oBoxValid <= nAny;
                    oXMin     <= nAny ? nXMin : '0;
                    oXMax     <= nAny ? nXMax : '0;
                    oYMin     <= nAny ? nYMin : '0;
                    oYMax     <= nAny ? nYMax : '0;
                end
            end
        end
    end

endmodule
